// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 responder model.
package ltc2308_pkg;
  localparam int DATA_W = 12;
  localparam int CFG_W  = 6;
  localparam int NUM_CH = 8;

  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [1:0] {ST_IDLE, ST_CONVERT, ST_SHIFT} state_t;

  // Channel decode ignores S/D: the odd/sign bit is the channel LSB.
  function automatic logic [2:0] cfg2chan(input logic [CFG_W-1:0] c);
    return {c[CFG_S1], c[CFG_S0], c[CFG_OS]};
  endfunction
endpackage

// File: rtl/ltc2308_if.sv
// Board-level ADC pins between an SPI ADC master and the converter.
interface ltc2308_if;
  logic ADC_CONVST;
  logic ADC_SCK;
  logic ADC_SDI;
  logic ADC_SDO;

  modport master (output ADC_CONVST, output ADC_SCK, output ADC_SDI, input ADC_SDO);
  modport slave  (input ADC_CONVST, input ADC_SCK, input ADC_SDI, output ADC_SDO);
endinterface

// File: rtl/ltc2308_emulator_sync_edge.sv
// Two-flop synchronizer with a third edge-history flop for rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], d};
  end

  assign q    = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];
endmodule

// File: rtl/ltc2308_emulator.sv
// Device-side LTC2308 model: takes CONVST/SCK/SDI from a master, returns the
// 12-bit code of the channel selected by the config in force at CONVST.
module ltc2308_emulator
  import ltc2308_pkg::*;
#(
  parameter int               CONV_CYCLES = 80,
  parameter logic [CFG_W-1:0] CFG_RESET   = 6'b100000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  ltc2308_if.slave                 adc,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [CFG_W-1:0]         cfg,
  output logic                     cfg_valid,
  output logic                     busy,
  output logic                     proto_err
);
  localparam int CNT_W = $clog2(CONV_CYCLES);

  logic conv_q, conv_rise, conv_fall;
  logic sck_q, sck_rise, sck_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  sync_edge u_sync_conv (.clk(clk), .rst_n(reset_n), .d(adc.ADC_CONVST),
                         .q(conv_q), .rise(conv_rise), .fall(conv_fall));
  sync_edge u_sync_sck  (.clk(clk), .rst_n(reset_n), .d(adc.ADC_SCK),
                         .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  sync_edge u_sync_sdi  (.clk(clk), .rst_n(reset_n), .d(adc.ADC_SDI),
                         .q(sdi_s), .rise(sdi_rise), .fall(sdi_fall));

  logic unused_ok;
  assign unused_ok = ^{conv_q, conv_fall, sck_q, sdi_rise, sdi_fall};

  logic [NUM_CH-1:0][DATA_W-1:0] ch_arr;
  assign ch_arr = ch_data;

  state_t            state, state_n;
  logic [CNT_W-1:0]  conv_cnt, conv_cnt_n;
  logic [DATA_W-1:0] hold, hold_n, tx_shift, tx_shift_n;
  logic [CFG_W-1:0]  rx_shift, rx_shift_n, cfg_r, cfg_n;
  logic [2:0]        rx_cnt, rx_cnt_n;
  logic [3:0]        tx_cnt, tx_cnt_n;
  logic              sdo_r, sdo_n, cfg_valid_n, proto_err_n;
  logic              start, wake;

  // CONVST is honoured outside CONVERT; a sleeping device only wakes up.
  assign start = conv_rise && (state != ST_CONVERT) && !cfg_r[CFG_SLP];
  assign wake  = conv_rise && (state != ST_CONVERT) &&  cfg_r[CFG_SLP];

  always_comb begin
    state_n     = state;
    conv_cnt_n  = conv_cnt;
    hold_n      = hold;
    tx_shift_n  = tx_shift;
    rx_shift_n  = rx_shift;
    cfg_n       = cfg_r;
    rx_cnt_n    = rx_cnt;
    tx_cnt_n    = tx_cnt;
    sdo_n       = sdo_r;
    cfg_valid_n = 1'b0;
    proto_err_n = 1'b0;

    case (state)
      ST_IDLE: begin
        if ((sck_rise || sck_fall) && !conv_rise) proto_err_n = 1'b1;
      end
      ST_CONVERT: begin
        if (sck_rise || sck_fall) proto_err_n = 1'b1;
        if (conv_cnt == '0) begin
          state_n    = ST_SHIFT;
          tx_shift_n = hold;
          sdo_n      = hold[DATA_W-1];
        end else begin
          conv_cnt_n = conv_cnt - CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        // A coincident CONVST rise takes priority; the SCK edge is dropped.
        if (!conv_rise) begin
          if (sck_rise && rx_cnt < 3'd6) begin
            rx_shift_n = {rx_shift[CFG_W-2:0], sdi_s};
            rx_cnt_n   = rx_cnt + 3'd1;
            if (rx_cnt == 3'd5) begin
              cfg_n       = {rx_shift[CFG_W-2:0], sdi_s};
              cfg_valid_n = 1'b1;
            end
          end
          if (sck_fall) begin
            if (tx_cnt == 4'(DATA_W-1)) begin
              sdo_n    = 1'b0;
              state_n  = ST_IDLE;
              tx_cnt_n = '0;
              rx_cnt_n = '0;
            end else begin
              tx_shift_n = {tx_shift[DATA_W-2:0], 1'b0};
              sdo_n      = tx_shift[DATA_W-2];
              tx_cnt_n   = tx_cnt + 4'd1;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (wake) cfg_n[CFG_SLP] = 1'b0;

    if (start) begin
      state_n    = ST_CONVERT;
      conv_cnt_n = CNT_W'(CONV_CYCLES - 1);
      hold_n     = ch_arr[cfg2chan(cfg_r)];
      rx_shift_n = '0;
      rx_cnt_n   = '0;
      tx_cnt_n   = '0;
      sdo_n      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      conv_cnt  <= '0;
      hold      <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      cfg_r     <= CFG_RESET;
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      sdo_r     <= 1'b0;
      cfg_valid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      conv_cnt  <= conv_cnt_n;
      hold      <= hold_n;
      tx_shift  <= tx_shift_n;
      rx_shift  <= rx_shift_n;
      cfg_r     <= cfg_n;
      rx_cnt    <= rx_cnt_n;
      tx_cnt    <= tx_cnt_n;
      sdo_r     <= sdo_n;
      cfg_valid <= cfg_valid_n;
      proto_err <= proto_err_n;
    end
  end

  assign cfg         = cfg_r;
  assign busy        = (state == ST_CONVERT);
  assign adc.ADC_SDO = sdo_r;
endmodule

// File: tb/tb_ltc2308_emulator.sv
// Randomized bench: drives the ADC pins like a master and compares frames
// against a channel/config model of the converter.
module tb_ltc2308_emulator;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [95:0] ch_data;
  logic [5:0]  cfg;
  logic        cfg_valid, busy, proto_err;

  ltc2308_if bus ();

  ltc2308_emulator #(.CONV_CYCLES(80), .CFG_RESET(6'b100000)) dut (
    .clk(clk), .reset_n(reset_n), .adc(bus), .ch_data(ch_data),
    .cfg(cfg), .cfg_valid(cfg_valid), .busy(busy), .proto_err(proto_err)
  );

  always #10 clk = ~clk;

  int        n_chk = 0, n_pass = 0;
  int        cv_cnt = 0, pe_cnt = 0;
  bit [11:0] chd [8];
  bit [5:0]  cfg_m;
  bit [11:0] exp_code;

  always @(negedge clk) begin
    if (cfg_valid === 1'b1) cv_cnt++;
    if (proto_err === 1'b1) pe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic set_ch(input int n, input bit [11:0] v);
    chd[n] = v;
    ch_data[12*n +: 12] = v;
  endtask

  function automatic int chan_of(input bit [5:0] c);
    return int'(c[3]) * 4 + int'(c[2]) * 2 + int'(c[4]);
  endfunction

  // Pulse CONVST; either a sleeping device wakes, or a conversion is timed.
  task automatic conv(output bit started);
    int lat = 0, len = 0, seen = 0;
    @(negedge clk) bus.ADC_CONVST = 1'b1;
    if (cfg_m[0]) begin
      repeat (10) begin @(negedge clk); if (busy) seen++; end
      bus.ADC_CONVST = 1'b0;
      cfg_m[0] = 1'b0;
      chk("slp_no_conv", seen, 0);
      chk("slp_wake_cfg", cfg, cfg_m);
      started = 1'b0;
      return;
    end
    exp_code = chd[chan_of(cfg_m)];
    while (!busy && lat < 20) begin @(negedge clk); lat++; end
    chk("busy_lat", lat, 3);
    bus.ADC_CONVST = 1'b0;
    while (busy && len < 200) begin len++; @(negedge clk); end
    chk("busy_len", len, 80);
    started = 1'b1;
  endtask

  task automatic frame(input bit [5:0] w, input int nsck, output bit [11:0] got);
    got = '0;
    for (int i = 0; i < nsck; i++) begin
      @(negedge clk) bus.ADC_SDI = (i < 6) ? w[5-i] : 1'b0;
      repeat (15) @(negedge clk);
      got = {got[10:0], bus.ADC_SDO};
      bus.ADC_SCK = 1'b1;
      repeat (16) @(negedge clk);
      bus.ADC_SCK = 1'b0;
    end
    if (nsck >= 6) cfg_m = w;
    if (nsck == 12) begin
      repeat (6) @(negedge clk);
      chk("sdo_after_frame", bus.ADC_SDO, 0);
    end
  endtask

  task automatic run_frame(input string tag, input bit [5:0] w);
    bit s; bit [11:0] got; int cv0;
    conv(s);
    if (!s) begin chk({tag, "_started"}, s, 1); return; end
    cv0 = cv_cnt;
    frame(w, 12, got);
    chk(tag, got, exp_code);
    chk({tag, "_cfg"}, cfg, cfg_m);
    chk({tag, "_cfg_valid"}, cv_cnt - cv0, 1);
  endtask

  initial begin
    bit s; bit [11:0] got; bit [5:0] w; int cv0, pe0, bz;
    bus.ADC_CONVST = 1'b0; bus.ADC_SCK = 1'b0; bus.ADC_SDI = 1'b0;
    ch_data = '0;
    for (int n = 0; n < 8; n++) set_ch(n, 12'($urandom));
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cfg_m = 6'b100000;
    @(negedge clk);
    chk("rst_sdo", bus.ADC_SDO, 0);
    chk("rst_cfg", cfg, 6'b100000);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_proto_err", proto_err, 0);

    set_ch(0, 12'hABC);
    run_frame("frame_ch0", 6'b110000);
    set_ch(1, 12'h123);
    run_frame("frame_ch1", {1'b1, 3'($urandom), 1'($urandom), 1'b0});

    for (int k = 0; k < 8; k++) begin
      bit [2:0] kb = 3'(k);
      for (int n = 0; n < 8; n++) set_ch(n, 12'($urandom));
      run_frame("sweep", {1'($urandom), kb[0], kb[2], kb[1], 1'($urandom), 1'b0});
    end

    // CONVST re-issued after three SCK cycles restarts the conversion
    conv(s);
    cv0 = cv_cnt;
    frame(6'b101101, 3, got);
    conv(s);
    chk("abort_cfg_kept", cfg, cfg_m);
    chk("abort_no_cfg_valid", cv_cnt - cv0, 0);
    w = {1'b1, 3'($urandom), 2'b00};
    frame(w, 12, got);
    chk("abort_next_frame", got, exp_code);

    // SCK activity during CONVERT
    pe0 = pe_cnt;
    fork
      conv(s);
      begin
        repeat (10) @(negedge clk);
        repeat (4) begin
          bus.ADC_SCK = ~bus.ADC_SCK;
          repeat (6) @(negedge clk);
        end
        chk("sdo_in_convert", bus.ADC_SDO, 0);
      end
    join
    chk("proto_err_pulses", pe_cnt - pe0, 4);
    frame({1'b1, 3'($urandom), 2'b00}, 12, got);
    chk("proto_frame", got, exp_code);

    // Sleep request: next CONVST only wakes the device
    run_frame("slp_set", {1'b1, 3'($urandom), 1'($urandom), 1'b1});
    conv(s);
    run_frame("after_wake", {1'b1, 3'($urandom), 1'($urandom), 1'b0});

    // Reset in the middle of a frame
    set_ch(chan_of(cfg_m), 12'hFFF);
    w = 6'b111010;
    conv(s);
    frame(w, 7, got);
    repeat (5) @(negedge clk);
    chk("pre_rst_sdo", bus.ADC_SDO, 1);
    chk("pre_rst_cfg", cfg, w);
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("midrst_sdo", bus.ADC_SDO, 0);
    chk("midrst_cfg", cfg, 6'b100000);
    chk("midrst_busy", busy, 0);
    cfg_m = 6'b100000;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bz = 0;
    repeat (20) begin @(negedge clk); if (busy) bz++; end
    chk("post_rst_idle", bz, 0);
    set_ch(0, 12'($urandom));
    run_frame("post_rst_frame", 6'b100100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/ltc2308_emulator.md
# ltc2308_emulator

Synthesizable responder model of the LTC2308 8-channel 12-bit SPI ADC, the device-side counterpart of the board-level ADC interface. It sits on the FPGA fabric in place of the physical converter, so ADC masters can be exercised in hardware loopback and simulation. It receives ADC_CONVST/ADC_SCK/ADC_SDI, latches the 6-bit configuration word, and returns the 12-bit code of the previously selected channel on ADC_SDO. Per-channel codes come from a register-fed input bus.

## Interface
- CONV_CYCLES, 80: clk cycles from CONVST rising edge to data ready (tCONV, 1.6 µs at 50 MHz).
- CFG_RESET, 6'b100000: configuration in force after reset (single-ended, CH0, bipolar, no sleep).
- clk  in  1  system clock; must be ≥ 8× ADC_SCK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- ADC_CONVST  in  1  conversion start from master (asynchronous to clk).
- ADC_SCK  in  1  serial clock from master (asynchronous to clk).
- ADC_SDI  in  1  configuration data from master, MSB first.
- ch_data  in  96  eight 12-bit codes; ch_data[12*n+11 : 12*n] is channel n.
- ADC_SDO  out  1  result data to master, MSB first.
- cfg  out  6  last complete config word {S/D, O/S, S1, S0, UNI, SLP}.
- cfg_valid  out  1  one-cycle pulse when cfg is updated.
- busy  out  1  high in CONVERT.
- proto_err  out  1  one-cycle pulse on an SCK edge outside SHIFT.

## Operation
- All three master inputs pass a 2-flop synchronizer, then an edge detector.
- States: IDLE, CONVERT, SHIFT.
  - IDLE → CONVERT on CONVST rise. Load the conversion counter with CONV_CYCLES−1. Snapshot active channel ch = {S1,S0,O/S} from cfg. Snapshot ch_data[ch] into hold.
  - CONVERT: count down to 0, then go to SHIFT. Load tx_shift = hold and set ADC_SDO = hold[11]. CONVST edges and SCK edges are ignored; SCK edges pulse proto_err.
  - SHIFT, on each SCK rise while bit_cnt < 6: shift ADC_SDI into rx_shift. On the 6th rise: cfg ← rx_shift, pulse cfg_valid.
  - SHIFT, on each SCK fall: tx_shift <<= 1 and ADC_SDO = next bit. After 12 falls, ADC_SDO = 0 and go to IDLE.
  - SHIFT, on CONVST rise: abort and enter CONVERT, as from IDLE. cfg is retained if fewer than 6 bits were received.
- S/D=0 (differential) and UNI are stored in cfg but do not alter data; channel decode is always {S1,S0,O/S}.
- SLP=1: the next CONVST rise is ignored and clears SLP in cfg (wake-up).
- A new config takes effect at the next conversion. The returned result is always that of the config in force at CONVST.

## Timing
- Reset values: ADC_SDO=0, cfg=CFG_RESET, cfg_valid=0, busy=0, proto_err=0, state=IDLE, all counters/shift registers 0.
- Input-edge-to-action latency: 3 clk (2 sync + 1 edge register).
- busy rises 3 clk after the CONVST pin rise and lasts exactly CONV_CYCLES clk.
- ADC_SDO valid by 4 clk after an SCK pin fall. The master samples on the next SCK rise, hence the ≥8× clk requirement.
- Simultaneous SCK rise and fall in one clk is impossible (synchronizer). CONVST rise in the same clk as an SCK edge: CONVST wins and the SCK edge is dropped.
- Reset asserted mid-SHIFT: immediate return to IDLE with all outputs at reset values.

## Structure
- ltc2308_pkg holds:
  - state enum
  - config field bit indices (CFG_SD=5 … CFG_SLP=0)
  - function cfg2chan
  - localparams DATA_W=12, CFG_W=6
- Sub-module sync_edge: 2-flop synchronizer plus rise/fall pulse outputs, instantiated three times.

## Test plan
- Reset, ch_data[0]=12'hABC, CONVST pulse, 12 SCK at 1.56 MHz (clk 50 MHz) → SDO stream 1010_1011_1100. cfg_valid fires once with the SDI word.
- Send config 6'b110000 (CH1), then a second conversion with ch_data[1]=12'h123 → second frame returns 12'h123; first frame returns CH0.
- Sweep all 8 channels using the codebase channel→{O/S,S1,S0} mapping (e.g. CH5 → 3'b110) → each frame returns the previous channel's ch_data.
- CONVST re-pulsed after 3 SCK → CONVERT restarts. cfg unchanged, cfg_valid not pulsed. Next frame is correct.
- SCK toggled during CONVERT → proto_err pulses per edge; SDO and frame data unaffected.
- reset_n dropped mid-SHIFT after 7 bits → ADC_SDO=0 and cfg=6'b100000 immediately. busy=0 until the next CONVST.
